interval_timer: RTL

- Transmitter side of the interval-to-synchronizer protocol. Models one temporal interval of an interactive score with a minimum and a maximum duration.
- Generates the per-interval event_min, event_finished, skip_p and kill_p pulses consumed by the interval controllers.
- One instance per interval. Outputs feed the controller of the interval's end point; start, skip_in and kill_in come from the start point's controller.

---
 rtl/is_pkg.sv | 25 ++
 rtl/sat_counter.sv | 34 +++
 rtl/interval_timer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/is_pkg.sv
// -----------------------------------------------------------------------------
// is_pkg
// Shared types for the interval timer and the score controllers that consume
// its pulses.
//   interval_state_t : one-hot state encoding of one temporal interval
//   is_terminal()    : true for the four sticky end states
// -----------------------------------------------------------------------------
package is_pkg;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_RUN     = 6'b000010,
    ST_DONE    = 6'b000100,
    ST_TIMEOUT = 6'b001000,
    ST_SKIPPED = 6'b010000,
    ST_KILLED  = 6'b100000
  } interval_state_t;

  // Terminal states hold elapsed and emit nothing until cleared.
  function automatic logic is_terminal(interval_state_t s);
    return (s == ST_DONE) || (s == ST_TIMEOUT) ||
           (s == ST_SKIPPED) || (s == ST_KILLED);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk : clock
//   rst : asynchronous active-high reset, q -> 0
//   clr : synchronous clear, q -> 0 (wins over en)
//   en  : advance by one when not saturated
//   q   : count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic saturated;

  assign saturated = (q == {WIDTH{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && !saturated) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
// Transmitter side of the interval-to-synchronizer protocol: models one
// temporal interval with a minimum and maximum duration and emits one pulse
// describing how the interval ended.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   tick            : time-base enable; elapsed advances on cycles with tick=1
//   start           : start point occurred; begins the interval
//   skip_in         : start point was skipped
//   kill_in         : kill request
//   clear           : return a terminal state to IDLE for reuse
//   trigger         : end-point user interaction
//   interactive     : 1 = end needs trigger, 0 = end automatically at d_min
//   d_min, d_max    : duration bounds in ticks, latched at start
//   event_min       : pulse, interval ended inside [d_min, d_max]
//   event_finished  : pulse, d_max reached without a valid end
//   skip_p, kill_p  : pulse, interval skipped / killed
//   running         : high while in RUN
//   elapsed         : ticks counted since start
//
// Handshake: there is no backpressure. Each pulse is a registered, single-cycle
// strobe appearing the cycle after the decision; at most one pulse fires per
// start..clear episode, and the consumer must sample it on that cycle.
// All outputs are registered; the state register is state_q.
// -----------------------------------------------------------------------------
module interval_timer
  import is_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             skip_in,
  input  logic             kill_in,
  input  logic             clear,
  input  logic             trigger,
  input  logic             interactive,
  input  logic [WIDTH-1:0] d_min,
  input  logic [WIDTH-1:0] d_max,
  output logic             event_min,
  output logic             event_finished,
  output logic             skip_p,
  output logic             kill_p,
  output logic             running,
  output logic [WIDTH-1:0] elapsed
);

  interval_state_t state_q, state_d;

  // Configuration captured at start so the interval is immune to later edits.
  logic [WIDTH-1:0] d_min_q, d_max_q;
  logic             interactive_q;
  logic             cfg_load;

  logic cnt_clr, cnt_en;

  logic ev_min_d, ev_fin_d, skip_d, kill_d;

  logic reached_min, within_max, reached_max, cfg_invalid;
  logic end_valid, time_out;

  // ---------------------------------------------------------------------------
  // Window comparisons on the registered elapsed value.
  // ---------------------------------------------------------------------------
  assign reached_min = (elapsed >= d_min_q);
  assign within_max  = (elapsed <= d_max_q);
  assign reached_max = (elapsed >= d_max_q);
  assign cfg_invalid = (d_min_q > d_max_q);

  assign end_valid = reached_min && within_max && (trigger || !interactive_q);

  // An empty window can never be satisfied, so it times out on the first RUN
  // evaluation rather than waiting for elapsed to crawl up to d_max.
  assign time_out = reached_max || cfg_invalid;

  // ---------------------------------------------------------------------------
  // Next-state and pulse decision.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    ev_min_d = 1'b0;
    ev_fin_d = 1'b0;
    skip_d   = 1'b0;
    kill_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (kill_in) begin
          state_d = ST_KILLED;
          kill_d  = 1'b1;
        end else if (skip_in) begin
          // Skip outranks a simultaneous start.
          state_d = ST_SKIPPED;
          skip_d  = 1'b1;
        end else if (start) begin
          state_d  = ST_RUN;
          cfg_load = 1'b1;
          cnt_clr  = 1'b1;
        end
      end

      ST_RUN: begin
        if (kill_in) begin
          state_d = ST_KILLED;
          kill_d  = 1'b1;
        end else if (end_valid) begin
          // Checked before time_out so a trigger at exactly d_max still counts
          // as a valid end.
          state_d  = ST_DONE;
          ev_min_d = 1'b1;
        end else if (time_out) begin
          state_d  = ST_TIMEOUT;
          ev_fin_d = 1'b1;
        end else begin
          cnt_en = tick;
        end
      end

      ST_DONE, ST_TIMEOUT, ST_SKIPPED, ST_KILLED: begin
        if (clear) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      end

      default: begin
        // Any non-one-hot value recovers to a clean IDLE.
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, configuration and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_min_q       <= '0;
      d_max_q       <= '0;
      interactive_q <= 1'b0;
    end else if (cfg_load) begin
      d_min_q       <= d_min;
      d_max_q       <= d_max;
      interactive_q <= interactive;
    end
  end

  // Pulses and running come from the same decision as state_d, so they line
  // up with the state register cycle for cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_min      <= 1'b0;
      event_finished <= 1'b0;
      skip_p         <= 1'b0;
      kill_p         <= 1'b0;
      running        <= 1'b0;
    end else begin
      event_min      <= ev_min_d;
      event_finished <= ev_fin_d;
      skip_p         <= skip_d;
      kill_p         <= kill_d;
      running        <= (state_d == ST_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Elapsed-time counter.
  // ---------------------------------------------------------------------------
  sat_counter #(
    .WIDTH (WIDTH)
  ) u_elapsed (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (elapsed)
  );

endmodule
